// File: rtl/otter_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the OTTER IO bus.
// Writes to DATA_ADDR queue bytes in a FIFO; STATUS_ADDR reads back busy/full/overflow/empty/count.
module otter_mmio_uart_tx #(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned BAUD        = 115200,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter logic [31:0] DATA_ADDR   = 32'h1100_0040,
   parameter logic [31:0] STATUS_ADDR = 32'h1100_0044
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] IO_ADDR,
   input  logic [31:0] IO_WR_DATA,
   input  logic        IO_WR,
   output logic [31:0] IO_RD_DATA,
   output logic        TX,
   output logic        TX_BUSY
);

   localparam int unsigned DIV = CLK_HZ / BAUD;
   localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam logic [BW-1:0] BAUD_LAST  = BW'(DIV - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          tx_q;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic full, empty, cell_end, pop, push_req, push, ovf_evt, clr_req;
   logic [8:0] count_ext;
   logic       unused_wr_bits;

   assign full      = (count == COUNT_FULL);
   assign empty     = (count == '0);
   assign cell_end  = (baud_cnt == BAUD_LAST);
   // The serialiser pops either from idle or on the last cycle of a stop bit.
   assign pop       = !empty && ((state == IDLE) || ((state == STOP) && cell_end));
   assign push_req  = IO_WR && (IO_ADDR == DATA_ADDR);
   assign push      = push_req && (!full || pop);
   assign ovf_evt   = push_req && !push;
   assign clr_req   = IO_WR && (IO_ADDR == STATUS_ADDR) && IO_WR_DATA[2];
   assign count_ext = 9'(count);
   assign unused_wr_bits = ^IO_WR_DATA[31:8];

   // NOTE: the byte storage is deliberately not reset; count/pointers define validity,
   // and keeping it out of the reset tree lets it map onto plain RAM.
   // When full with a simultaneous pop, wr_ptr==rd_ptr: the pop sees the old byte,
   // the push overwrites the slot at the same edge.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= IO_WR_DATA[7:0];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (ovf_evt)      overflow <= 1'b1;
         else if (clr_req) overflow <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx_q     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shreg    <= mem[rd_ptr];
                  baud_cnt <= '0;
                  state    <= START;
                  tx_q     <= 1'b0;
               end
            end
            START: begin
               if (cell_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  tx_q     <= shreg[0];
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            DATA: begin
               if (cell_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx_q  <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_q    <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            STOP: begin
               if (cell_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shreg <= mem[rd_ptr];
                     state <= START;
                     tx_q  <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx_q  <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            default: begin
               state <= IDLE;
               tx_q  <= 1'b1;
            end
         endcase
      end
   end

   assign TX      = tx_q;
   assign TX_BUSY = (state != IDLE) || !empty;

   always_comb begin
      IO_RD_DATA = '0;
      if (IO_ADDR == STATUS_ADDR)
         IO_RD_DATA = {19'b0, count_ext, empty, overflow, full, TX_BUSY};
   end

endmodule
